camo_key_loader: RTL
====================

# camo_key_loader

Serial key-delivery block for camouflaged/obfuscated netlists. It receives the camouflage configuration key as a framed bit stream over a valid/ready handshake and checks frame length and parity. It then atomically commits the key to the `D` select bus that drives every 4-way obfuscation cell (pass / invert / const1 / const0). It sits between the key-provisioning port (tester or secure fuse reader) and the obfuscated core, and is the producer for the `D_*` inputs the core consumes.

## Interface
- `NUM_CELLS`, 5: number of obfuscated cells. Each cell takes a 2-bit select, so the key is `2*NUM_CELLS` bits.
- `ERR_W`, 8: width of the saturating error counter.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: reset. Reset is synchronous and active-low.
- `key_valid` input 1: serial key bit is valid.
- `key_ready` output 1: block accepts a bit this cycle.
- `key_bit` input 1: serial key data.
- `key_last` input 1: marks the final bit of the frame, which is the parity bit.
- `lock` input 1: when 1 at commit time, sets `key_locked`.
- `D` output 2*NUM_CELLS: committed select bus. Cell k uses the pair (`D[2k]`, `D[2k+1]`).
- `cfg_apply` output 1: one-cycle pulse when `D` has just been updated.
- `key_err` output 1: one-cycle pulse when a frame is rejected.
- `key_locked` output 1: sticky. Once set, all later frames are rejected.
- `err_cnt` output ERR_W: count of rejected frames. Saturates at all-ones.

## Operation
- Frame format:
  - `2*NUM_CELLS` key bits, LSB first. The first bit goes to `D[0]`.
  - Followed by one even-parity bit. The XOR of all `2*NUM_CELLS+1` bits must be 0.
  - `key_last` is asserted only on the parity bit.
- Cell codes for (`D[2k]`, `D[2k+1]`):
  - (0,0) pass.
  - (0,1) invert.
  - (1,0) const1.
  - (1,1) const0.
  - All four codes are legal.
- A bit is accepted on any cycle with `key_valid & key_ready`. Bits accumulate in a shadow shift register. `D` changes only on commit, never mid-frame.
- States:
  - IDLE: `key_ready`=1. The first accepted bit moves the block to SHIFT, or to CHECK if `key_last` is set on that bit.
  - SHIFT: `key_ready`=1. The bit counter increments per accepted bit.
    - An accepted bit with `key_last` goes to CHECK.
    - If `2*NUM_CELLS+1` bits are accepted without `key_last`, go to DRAIN with the length error flagged.
  - DRAIN: `key_ready`=1. Bits are discarded until a bit with `key_last` is accepted, then go to CHECK with the length error flagged.
  - CHECK: `key_ready`=0 for exactly one cycle, then back to IDLE.
    - The frame is accepted only if the count is exactly `2*NUM_CELLS+1`, parity is good, and `key_locked` is 0.
    - Accepted frame: `D` is loaded from the shadow register and `cfg_apply` pulses. If `lock`=1, `key_locked` is set.
    - Rejected frame: `key_err` pulses, `err_cnt` increments (saturating), and `D` is unchanged.
- The bit counter is `$clog2(2*NUM_CELLS+2)` bits wide and saturates. It never wraps.

## Timing
- Reset values, all applied synchronously while `rst_n`=0:
  - `D`=0 (every cell in pass).
  - `key_ready`=0.
  - `cfg_apply`=0, `key_err`=0.
  - `key_locked`=0, `err_cnt`=0.
  - State = IDLE. Shadow register and counter cleared.
- `key_ready`=1 from the first cycle after reset release.
- Latency: let E0 be the edge at which the last bit is accepted.
  - State is CHECK during cycle E0..E1.
  - At E1, `D`, `cfg_apply`, `key_err`, `err_cnt` and `key_locked` update together.
  - `key_ready` returns to 1 at E1.
- `cfg_apply` and `key_err` are never high in the same cycle. Each is high for exactly one cycle.
- Reset asserted mid-frame discards the partial frame and returns every output to its reset value, including `D`=0.
- `key_valid` while `key_ready`=0 is ignored. The bit is not consumed.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `camo_pkg` holds:
  - Code constants `CAMO_PASS`=2'b00, `CAMO_INV`=2'b10, `CAMO_C1`=2'b01, `CAMO_C0`=2'b11. These are written as {`D[2k+1]`,`D[2k]`}.
  - The state enum `camo_ld_state_t` {IDLE, SHIFT, DRAIN, CHECK}.
  - Helper function `camo_key_w(n)`=2*n+1.
- One natural sub-module: `camo_frame_rx`. It contains the shift register, bit counter and running parity, and outputs `frame_done`, `len_ok` and `par_ok`. The top level holds the FSM, the commit registers and the counters.

## Test plan
- Good frame, NUM_CELLS=5: key 10'b10_01_00_11_10 plus parity 1 with `key_last`, `lock`=0.
  - Response: one cycle after the last bit, `D`=10'b1001001110, `cfg_apply`=1 for 1 cycle, `err_cnt`=0.
- Bad parity: same key with parity 0.
  - Response: `key_err` pulse, `err_cnt`=1, `D` keeps its previous value.
- Short frame: `key_last` on bit 6.
  - Response: `key_err`, `err_cnt`+1, `D` unchanged, `key_ready`=1 one cycle later.
- Long frame: 14 bits, `key_last` on bit 14.
  - Response: DRAIN consumes all 14 bits, then `key_err`, `D` unchanged.
- Lock: good frame with `lock`=1, then a second good frame with a different key.
  - Response: first frame commits and sets `key_locked`=1. Second frame gives `key_err` and `D` holds the first key.
- Reset mid-frame: `rst_n`=0 after 4 bits.
  - Response: `D`=0 and `err_cnt`=0. A following good frame commits normally.
- Backpressure: toggle `key_valid` randomly during a frame.
  - Response: only handshaked bits are counted, and the result matches the good-frame case.

Source files
------------

// File: rtl/camo_pkg.sv
// Shared definitions for the camouflage key loader: cell select codes,
// loader state encoding and the frame-length helper.
package camo_pkg;

   // Cell select codes, written as {D[2k+1], D[2k]}
   localparam logic [1:0] CAMO_PASS = 2'b00;
   localparam logic [1:0] CAMO_INV  = 2'b10;
   localparam logic [1:0] CAMO_C1   = 2'b01;
   localparam logic [1:0] CAMO_C0   = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DRAIN,
      CHECK
   } camo_ld_state_t;

   // Frame length in bits: two select bits per cell plus the parity bit
   function automatic int camo_key_w(input int n);
      return 2 * n + 1;
   endfunction

endpackage

// File: rtl/camo_frame_rx.sv
// Serial frame receiver: shadow shift register, saturating bit counter and
// running parity for one key frame. Cleared by the loader between frames.
module camo_frame_rx
   import camo_pkg::*;
#(
   parameter int NUM_CELLS = 5
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_clear,
   input  logic                                 i_accept,
   input  logic                                 i_bit,
   input  logic                                 i_last,
   output logic                                 o_frame_done,
   output logic                                 o_len_ok,
   output logic                                 o_par_ok,
   output logic [2*NUM_CELLS-1:0]               o_shadow,
   output logic [$clog2(2*NUM_CELLS+2)-1:0]     o_count
);

   localparam int KEY_BITS = 2 * NUM_CELLS;
   localparam int KEY_W    = camo_key_w(NUM_CELLS);
   localparam int CNT_W    = $clog2(KEY_BITS + 2);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_KEY  = CNT_W'(KEY_W);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(KEY_BITS);

   logic [KEY_BITS-1:0] r_shadow;
   logic [CNT_W-1:0]    r_count;
   logic                r_parity;

   // Bits enter at the top and move down, so the first bit ends in bit 0.
   // The parity bit and any overflow bits are kept out of the shadow.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_shadow <= '0;
         r_count  <= '0;
         r_parity <= 1'b0;
      end else if (i_accept) begin
         if (r_count != CNT_MAX)
            r_count <= r_count + 1'b1;
         r_parity <= r_parity ^ i_bit;
         if (r_count < CNT_DATA)
            r_shadow <= {i_bit, r_shadow[KEY_BITS-1:1]};
      end
   end

   assign o_frame_done = i_accept & i_last;
   assign o_len_ok     = (r_count == CNT_KEY);
   assign o_par_ok     = ~r_parity;
   assign o_shadow     = r_shadow;
   assign o_count      = r_count;

endmodule

// File: rtl/camo_key_loader.sv
// Key loader top: frame FSM, atomic commit of the select bus D, lock flag
// and saturating rejected-frame counter.
module camo_key_loader
   import camo_pkg::*;
#(
   parameter int NUM_CELLS = 5,
   parameter int ERR_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   key_valid,
   output logic                   key_ready,
   input  logic                   key_bit,
   input  logic                   key_last,
   input  logic                   lock,
   output logic [2*NUM_CELLS-1:0] D,
   output logic                   cfg_apply,
   output logic                   key_err,
   output logic                   key_locked,
   output logic [ERR_W-1:0]       err_cnt
);

   localparam int KEY_BITS = 2 * NUM_CELLS;
   localparam int KEY_W    = camo_key_w(NUM_CELLS);
   localparam int CNT_W    = $clog2(KEY_BITS + 2);

   localparam logic [CNT_W-1:0] CNT_LAST_OK = CNT_W'(KEY_W - 1);

   camo_ld_state_t      r_state;
   logic                r_ready;
   logic [KEY_BITS-1:0] r_d;
   logic                r_apply;
   logic                r_err;
   logic                r_locked;
   logic [ERR_W-1:0]    r_errCnt;
   logic                r_lenErr;

   logic                w_accept;
   logic                w_rxClear;
   logic                w_frameDone;
   logic                w_lenOk;
   logic                w_parOk;
   logic [KEY_BITS-1:0] w_shadow;
   logic [CNT_W-1:0]    w_count;

   assign w_accept  = key_valid & r_ready;
   assign w_rxClear = (r_state == CHECK);

   camo_frame_rx #(
      .NUM_CELLS (NUM_CELLS)
   ) u_rx (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (w_rxClear),
      .i_accept     (w_accept),
      .i_bit        (key_bit),
      .i_last       (key_last),
      .o_frame_done (w_frameDone),
      .o_len_ok     (w_lenOk),
      .o_par_ok     (w_parOk),
      .o_shadow     (w_shadow),
      .o_count      (w_count)
   );

   // A frame that runs past its full length without key_last is drained
   // until key_last arrives, so the sender stays in step with frame edges.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_ready  <= 1'b0;
         r_d      <= {NUM_CELLS{CAMO_PASS}};
         r_apply  <= 1'b0;
         r_err    <= 1'b0;
         r_locked <= 1'b0;
         r_errCnt <= '0;
         r_lenErr <= 1'b0;
      end else begin
         r_apply <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_lenErr <= 1'b0;
                  if (w_frameDone) begin
                     r_state <= CHECK;
                     r_ready <= 1'b0;
                  end else begin
                     r_state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (w_frameDone) begin
                  r_state <= CHECK;
                  r_ready <= 1'b0;
               end else if (w_accept && (w_count == CNT_LAST_OK)) begin
                  r_state  <= DRAIN;
                  r_lenErr <= 1'b1;
               end
            end
            DRAIN: begin
               if (w_frameDone) begin
                  r_state <= CHECK;
                  r_ready <= 1'b0;
               end
            end
            CHECK: begin
               if (!r_lenErr && w_lenOk && w_parOk && !r_locked) begin
                  r_d     <= w_shadow;
                  r_apply <= 1'b1;
                  if (lock)
                     r_locked <= 1'b1;
               end else begin
                  r_err <= 1'b1;
                  if (r_errCnt != '1)
                     r_errCnt <= r_errCnt + 1'b1;
               end
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign key_ready  = r_ready;
   assign D          = r_d;
   assign cfg_apply  = r_apply;
   assign key_err    = r_err;
   assign key_locked = r_locked;
   assign err_cnt    = r_errCnt;

endmodule
